// File: rtl/dmem_wb_pkg.sv
// Shared definitions for the data-memory Wishbone master:
// FSM state encodings, the value returned on a failed access and
// the timeout defaults used when DMEM_WB_TIMEOUT_EN is defined.
package dmem_wb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUS  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Data loaded into the read register on a bus error or timeout.
    localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;

    // Default number of BUS cycles before a forced abort.
    localparam int unsigned DMEM_TIMEOUT_DEF = 255;

    localparam int unsigned DMEM_TO_CNT_W = 16;
    typedef logic [DMEM_TO_CNT_W-1:0] to_cnt_t;

endpackage

// File: rtl/dmem_wb_timeout.sv
// Bus-cycle watchdog for dmem_wb_master. Only instantiated when
// DMEM_WB_TIMEOUT_EN is defined. The counter clears when an access is
// launched and counts BUS cycles. 'expired' is raised during the
// TIMEOUT_CYCLES-th BUS cycle, so the abort happens on that cycle's edge.
module dmem_wb_timeout
    import dmem_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic in_bus,
    output logic expired
);

    localparam to_cnt_t LIMIT = to_cnt_t'(TIMEOUT_CYCLES - 1);

    to_cnt_t cnt_q;

    // Clear on launch, count BUS cycles, saturate at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (in_bus && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = in_bus & (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_wb_master.sv
// Data-memory bus adapter: turns each core load/store into one
// Wishbone B4 classic single read or write. It holds the core with a
// combinational Stall while the access is in flight. Read data is
// returned from a register that only changes when an access completes.
// Optional feature macro: DMEM_WB_TIMEOUT_EN. When it is defined, a stuck
// slave is aborted after TIMEOUT_CYCLES BUS cycles.
module dmem_wb_master
    import dmem_wb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       Addr,
    input  logic [31:0]       WriteData,
    input  logic [3:0]        ByteSel,
    output logic [31:0]       ReadData,
    output logic              Stall,
    output logic              BusErr,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    output logic [3:0]        wb_sel_o,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    state_t      state_q;
    state_t      state_d;
    logic        req;
    logic        in_idle;
    logic        in_bus;
    logic        launch;
    logic        to_expired;
    logic        bus_end;
    logic        bus_fail;
    logic        we_q;
    logic [31:0] rd_q;
    logic        err_q;

    assign req     = MemRead | MemWrite;
    assign in_idle = (state_q == ST_IDLE);
    assign in_bus  = (state_q == ST_BUS);
    assign launch  = in_idle & req;

    // Priority on completion: err beats ack, and ack beats the timeout.
    assign bus_end  = in_bus & (wb_ack_i | wb_err_i | to_expired);
    assign bus_fail = in_bus & (wb_err_i | (to_expired & ~wb_ack_i));

`ifdef DMEM_WB_TIMEOUT_EN
    dmem_wb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .start   (launch),
        .in_bus  (in_bus),
        .expired (to_expired)
    );
`else
    // Without the watchdog BUS waits for the slave indefinitely.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign to_expired         = 1'b0;
`endif

    // Word-aligned bus: the byte offset is expressed only through ByteSel.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^Addr[1:0];

    // Next-state selection. A request seen in DONE is never re-issued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req)     state_d = ST_BUS;
            ST_BUS:  if (bus_end) state_d = ST_DONE;
            ST_DONE:              state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    // State register. An async reset also drops cyc/stb immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the request when it is accepted. Write wins over read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q     <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
        end else if (launch) begin
            we_q     <= MemWrite;
            wb_adr_o <= {Addr[ADDR_W-1:2], 2'b00};
            wb_dat_o <= WriteData;
            wb_sel_o <= ByteSel;
        end
    end

    // Completion capture: read data or error pattern, plus a one-cycle error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= bus_fail;
            if (bus_fail) begin
                rd_q <= DMEM_ERR_DATA;
            end else if (bus_end && !we_q) begin
                rd_q <= wb_dat_i;
            end
        end
    end

    assign wb_cyc_o = in_bus;
    assign wb_stb_o = in_bus;
    assign wb_we_o  = we_q;
    assign ReadData = rd_q;
    assign BusErr   = err_q;

    // Stall never depends on the slave inputs. It is also forced low during reset.
    assign Stall = reset & (launch | in_bus);

endmodule

// File: tb/tb_dmem_wb_master.sv
// Self-checking bench for dmem_wb_master. A bench-side slave answers each
// access after a chosen number of BUS cycles with ack, err or both. The
// expected bus fields, latency and returned data follow from the access
// rules and are tracked in model_rd.
module tb_dmem_wb_master;

    localparam int unsigned TO_CYC = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Addr = '0;
    logic [31:0] WriteData = '0;
    logic [3:0]  ByteSel = '0;
    logic [31:0] ReadData;
    logic        Stall;
    logic        BusErr;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    int          total = 0;
    int          bad = 0;
    logic [31:0] model_rd = '0;

    dmem_wb_master #(
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ByteSel   (ByteSel),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .BusErr    (BusErr),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i)
    );

    always #5 clk = ~clk;

    // One access: the slave answers in BUS cycle n. kind 0=ack, 1=err, 2=ack+err.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] sel,
                             input int n, input int kind, input logic [31:0] sdata);
        logic [31:0] exp_adr;
        logic [31:0] exp_rd;
        logic        exp_be;
        int          stall_obs;
        exp_adr = {a[31:2], 2'b00};
        exp_be  = (kind != 0);
        if (kind != 0)   exp_rd = 32'hDEAD_BEEF;
        else if (wr)     exp_rd = model_rd;
        else             exp_rd = sdata;

        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; Addr = a; WriteData = wd; ByteSel = sel;
        @(negedge clk);
        total++;
        if ({Stall, wb_cyc_o, wb_stb_o, BusErr} !== 4'b1000 || ReadData !== model_rd) begin
            bad++;
            $display("FAIL detect: stall/cyc/stb/err=%b rd=%h, want 1000 rd=%h",
                     {Stall, wb_cyc_o, wb_stb_o, BusErr}, ReadData, model_rd);
        end
        stall_obs = Stall ? 1 : 0;

        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            wb_ack_i = (k == n) && (kind != 1);
            wb_err_i = (k == n) && (kind != 0);
            wb_dat_i = (k == n) ? sdata : $urandom;
            @(negedge clk);
            if (Stall) stall_obs++;
            total++;
            if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, ReadData, BusErr} !==
                {2'b11, wr, exp_adr, wd, sel, model_rd, 1'b0}) begin
                bad++;
                $display("FAIL bus_cycle%0d: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%b rd=%h err=%b, want 1 1 %b %h %h %b %h 0",
                         k, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, ReadData, BusErr,
                         wr, exp_adr, wd, sel, model_rd);
            end
        end

        @(posedge clk); #1;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
        @(negedge clk);
        total++;
        if ({wb_cyc_o, wb_stb_o, Stall} !== 3'b000) begin
            bad++;
            $display("FAIL done_ctl: cyc/stb/stall=%b, want 000", {wb_cyc_o, wb_stb_o, Stall});
        end
        total++;
        if (ReadData !== exp_rd) begin
            bad++;
            $display("FAIL done_data: ReadData=%h, want %h", ReadData, exp_rd);
        end
        total++;
        if (BusErr !== exp_be) begin
            bad++;
            $display("FAIL done_buserr: BusErr=%b, want %b", BusErr, exp_be);
        end
        total++;
        if (stall_obs != n + 1) begin
            bad++;
            $display("FAIL stall_len: stall cycles=%0d, want %0d", stall_obs, n + 1);
        end
        model_rd = exp_rd;
    endtask

    // Drop the request and check that the master stays idle and quiet.
    task automatic idle_cycle();
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        @(negedge clk);
        total++;
        if ({wb_cyc_o, wb_stb_o, Stall, BusErr} !== 4'b0000 || ReadData !== model_rd) begin
            bad++;
            $display("FAIL idle: cyc/stb/stall/err=%b rd=%h, want 0000 rd=%h",
                     {wb_cyc_o, wb_stb_o, Stall, BusErr}, ReadData, model_rd);
        end
    endtask

    task automatic test_reset();
        MemRead = 1'b1;
        Addr = 32'hFFFF_FFFF;
        WriteData = 32'hFFFF_FFFF;
        ByteSel = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, ReadData, BusErr, Stall} !== '0) begin
            bad++;
            $display("FAIL reset_state: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%b rd=%h err=%b stall=%b, want all 0",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, ReadData, BusErr, Stall);
        end
        MemRead = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_rd = '0;
        idle_cycle();
    endtask

    task automatic test_load_first_ack();
        do_access(1'b1, 1'b0, 32'h0000_1003, 32'h0, 4'hF, 1, 0, 32'hCAFE_F00D);
        idle_cycle();
    endtask

    task automatic test_store_wait();
        do_access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011, 5, 0, 32'h9999_9999);
        idle_cycle();
    endtask

    task automatic test_both_err_ack();
        do_access(1'b1, 1'b1, 32'h0000_0444, 32'hA5A5_5A5A, 4'b1100, 2, 2, 32'h0BAD_0BAD);
        idle_cycle();
    endtask

    task automatic test_timeout();
        int cyc_cnt;
        @(posedge clk); #1;
        MemRead = 1'b1; Addr = 32'h0000_0100;
        cyc_cnt = 0;
`ifdef DMEM_WB_TIMEOUT_EN
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (!wb_cyc_o) break;
            cyc_cnt++;
        end
        total++;
        if (cyc_cnt != TO_CYC) begin
            bad++;
            $display("FAIL timeout_len: cyc high %0d cycles, want %0d", cyc_cnt, TO_CYC);
        end
        total++;
        if ({Stall, BusErr} !== 2'b01 || ReadData !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL timeout_done: stall=%b err=%b rd=%h, want 0 1 deadbeef", Stall, BusErr, ReadData);
        end
        model_rd = 32'hDEAD_BEEF;
        idle_cycle();
        do_access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'hF, TO_CYC, 0, 32'h7777_1111);
        idle_cycle();
`else
        for (int k = 0; k < 120; k++) begin
            @(posedge clk); #1;
            MemRead = 1'b0;
            @(negedge clk);
            if (wb_cyc_o && Stall && !BusErr) cyc_cnt++;
        end
        total++;
        if (cyc_cnt != 120) begin
            bad++;
            $display("FAIL no_timeout: stalled %0d of 120 cycles, want 120", cyc_cnt);
        end
        @(posedge clk); #1;
        wb_ack_i = 1'b1; wb_dat_i = 32'h7777_1111;
        @(posedge clk); #1;
        wb_ack_i = 1'b0; wb_dat_i = '0;
        @(negedge clk);
        total++;
        if ({Stall, wb_cyc_o, BusErr} !== 3'b000 || ReadData !== 32'h7777_1111) begin
            bad++;
            $display("FAIL late_ack: stall=%b cyc=%b err=%b rd=%h, want 0 0 0 77771111",
                     Stall, wb_cyc_o, BusErr, ReadData);
        end
        model_rd = 32'h7777_1111;
        idle_cycle();
`endif
    endtask

    task automatic test_reset_mid_bus();
        @(posedge clk); #1;
        MemRead = 1'b1; MemWrite = 1'b0; Addr = 32'h0000_0808;
        repeat (3) @(posedge clk);
        #2;
        total++;
        if ({wb_cyc_o, Stall} !== 2'b11) begin
            bad++;
            $display("FAIL bus3_pre: cyc/stall=%b, want 11", {wb_cyc_o, Stall});
        end
        reset = 1'b0;
        #1;
        total++;
        if ({wb_cyc_o, wb_stb_o, Stall} !== 3'b000) begin
            bad++;
            $display("FAIL async_drop: cyc/stb/stall=%b, want 000", {wb_cyc_o, wb_stb_o, Stall});
        end
        wb_ack_i = 1'b1; wb_dat_i = 32'h5555_AAAA;
        @(posedge clk); #1;
        MemRead = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        model_rd = '0;
        total++;
        if ({wb_cyc_o, BusErr, Stall} !== 3'b000 || ReadData !== 32'h0) begin
            bad++;
            $display("FAIL stray_ack: cyc/err/stall=%b rd=%h, want 000 rd=0",
                     {wb_cyc_o, BusErr, Stall}, ReadData);
        end
        @(posedge clk); #1;
        wb_ack_i = 1'b0;
        idle_cycle();
        do_access(1'b1, 1'b0, 32'h0000_0C0E, 32'h0, 4'hF, 2, 0, 32'h1357_9BDF);
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            int r;
            int kr;
            int kind;
            logic rd;
            logic wr;
            r  = $urandom_range(0, 2);
            kr = $urandom_range(0, 5);
            kind = (kr < 4) ? 0 : ((kr == 4) ? 1 : 2);
            rd = (r != 1);
            wr = (r != 0);
            do_access(rd, wr, $urandom, $urandom, 4'($urandom_range(1, 15)),
                      $urandom_range(1, 5), kind, $urandom);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_first_ack();
        test_store_wait();
        test_both_err_ack();
        test_timeout();
        test_reset_mid_bus();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_wb_master.md
# dmem_wb_master

Data-memory bus adapter placed directly downstream of the single-cycle RISC-V core's data port (MemWrite/ALUResult/WriteData/ReadData). Converts each core load or store into one Wishbone B4 classic single-read/single-write cycle. While the access is in flight it drives a combinational stall so the core's PC and register writes freeze. Returns the read data registered.

## Interface
Parameters:
- `ADDR_W`, 32: Wishbone address width.
- `TIMEOUT_CYCLES`, 255: bus cycles in BUS before a forced abort. Only used with `DMEM_WB_TIMEOUT_EN`.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low reset (asserted when 0).
- `MemRead`  in  1: core load request, valid for the whole cycle.
- `MemWrite`  in  1: core store request.
- `Addr`  in  32: byte address (core `ALUResult`).
- `WriteData`  in  32: store data.
- `ByteSel`  in  4: byte-lane enables.
- `ReadData`  out  32: load result.
- `Stall`  out  1: freezes the core.
- `BusErr`  out  1: one-cycle error pulse.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1 each: Wishbone cycle, strobe and write-enable.
- `wb_adr_o`  out  `ADDR_W`: Wishbone address.
- `wb_dat_o`  out  32: Wishbone write data.
- `wb_sel_o`  out  4: Wishbone byte selects.
- `wb_dat_i`  in  32: Wishbone read data.
- `wb_ack_i`, `wb_err_i`  in  1 each: Wishbone acknowledge and error.

## Operation
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - If `MemRead|MemWrite`, assert `Stall` combinationally in the same cycle.
  - Latch the request: `Addr[ADDR_W-1:2],2'b00` → `wb_adr_o`, `WriteData`, `ByteSel`, and we = `MemWrite`.
  - Go to BUS.
  - If `MemRead` and `MemWrite` are both high, the write wins.
- BUS:
  - `wb_cyc_o`, `wb_stb_o` and `Stall` are 1; `wb_we`/`wb_adr`/`wb_dat`/`wb_sel` hold the latched values.
  - On `wb_ack_i`: capture `wb_dat_i` into the read register (reads only; writes leave it unchanged) and go to DONE.
  - On `wb_err_i`: load 32'hDEAD_BEEF into the read register, set the error flag and go to DONE.
  - If `wb_ack_i` and `wb_err_i` are both high, err has priority.
- DONE:
  - `cyc`/`stb` are 0 and `Stall` is 0, so the core retires the instruction at this edge.
  - `ReadData` = read register; `BusErr` = error flag for this one cycle.
  - Go to IDLE unconditionally. The request seen in DONE is never re-issued.
- `ReadData` holds its last value in every state. It is only updated at the BUS→DONE transition.
- Reset (async, any state): state IDLE; `cyc`/`stb`/`we` = 0; `wb_adr_o`/`wb_dat_o` = 0; `wb_sel_o` = 0; `ReadData` = 0; `BusErr` = 0; counter = 0.
  - Reset during BUS drops `cyc`/`stb` immediately, without waiting for the clock edge.
  - An `ack` arriving after reset is ignored.

## Timing
- `Stall` = (state==IDLE & (`MemRead|MemWrite`)) | (state==BUS). It is combinational and has no dependency on `wb_*_i`.
- Minimum access: 3 cycles (IDLE detect, BUS with ack in the first BUS cycle, DONE).
- An ack after N BUS cycles gives N+2 cycles total.
- `cyc`/`stb` rise one edge after the request is detected. They fall on the edge that samples `ack`/`err`. They never stay high in DONE.
- Back-to-back accesses: minimum 3 cycles apart. IDLE can begin a new access the cycle after DONE.

## Configuration
- `DMEM_WB_TIMEOUT_EN` defined:
  - An 8..16-bit counter clears on entry to BUS and increments each BUS cycle.
  - When it reaches `TIMEOUT_CYCLES` with no ack/err, it behaves exactly like `wb_err_i`: DEAD_BEEF, `BusErr` pulse, DONE.
  - An ack in the same cycle as expiry wins over the timeout.
- `DMEM_WB_TIMEOUT_EN` not defined:
  - No counter; BUS waits indefinitely.
  - `TIMEOUT_CYCLES` is ignored.

## Structure
- Shared package `dmem_wb_pkg` holds:
  - the state enum (IDLE/BUS/DONE);
  - `DMEM_ERR_DATA` = 32'hDEAD_BEEF;
  - the default `TIMEOUT_CYCLES`.
- Optional sub-module `dmem_wb_timeout`: counter plus expiry compare. It is instantiated only under `DMEM_WB_TIMEOUT_EN`. Everything else lives in one module.

## Test plan
- Load with ack on the first BUS cycle: `Addr`=0x1003, slave returns 0xCAFE_F00D → `wb_adr_o`=0x1000, `we`=0; `Stall` high for 2 cycles; `ReadData`=0xCAFE_F00D in DONE; `BusErr`=0.
- Store with ack after a 4-cycle wait: `Addr`=0x20, `WriteData`=0x1234_5678, `ByteSel`=4'b0011 → `wb_dat_o`/`wb_sel_o` stable for 5 BUS cycles; 7-cycle access total; `ReadData` unchanged.
- `MemRead`=`MemWrite`=1 → `wb_we_o`=1. Then `wb_err_i` and `ack` arrive together → `ReadData`=0xDEAD_BEEF and a single-cycle `BusErr`.
- With `DMEM_WB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8 and a slave that never acks → `cyc` drops after 8 BUS cycles; `BusErr` pulses; `Stall` falls in DONE. Without the macro, `Stall` stays high for 100+ cycles.
- Reset asserted in the 3rd BUS cycle → `cyc`/`stb`/`Stall` fall before the next edge. A late `ack` is ignored. After release, a fresh load completes normally.
